dmem_arbiter: RTL and testbench

- Shares the single-ported data memory between two requesters.
- Port 0 is the CPU load/store unit and has fixed priority. Port 1 is the secondary master (loader/debug/DMA).
- A starvation guard forces a port-1 grant after too many consecutive port-0 grants.
- Drives the memory's byte-address, write-data, MemWrite and MemRead inputs. Captures combinational read data into per-port registered responses.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arb_resp.sv | 27 ++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    PRIO0,
    PRIO1
  } arb_state_t;

  localparam int unsigned PORT_CPU   = 0;
  localparam int unsigned PORT_AUX   = 1;
  localparam int unsigned HOLD_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-port read-capture register: latches memory read data at the end of a
// read grant and pulses rvalid for exactly the following cycle.
module dmem_arb_resp #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  // Capture read data on a read grant; rdata holds until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory. Port 0 (CPU) has fixed
// priority; a starvation guard forces a port-1 grant after MAX_HOLD
// consecutive port-0 grants while port 1 waits.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,

  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] memReadData
);

  arb_state_t            state, state_nxt;
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [1:0]            gnt;

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PRIO0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Grant selection and next-state logic.
  // Reaching MAX_HOLD moves to PRIO1 with the counter already cleared, so
  // every exit from PRIO1 sees holdCnt = 0 without extra logic there.
  always_comb begin
    gnt          = '0;
    state_nxt    = PRIO0;
    hold_cnt_nxt = '0;
    if (reset_n) begin
      if (state == PRIO1 && req1) begin
        gnt[PORT_AUX] = 1'b1;
      end else if (req0) begin
        gnt[PORT_CPU] = 1'b1;
      end else if (req1) begin
        gnt[PORT_AUX] = 1'b1;
      end
      if (state == PRIO0 && gnt[PORT_CPU] && req1) begin
        if (hold_cnt == HOLD_CNT_W'(MAX_HOLD - 1)) begin
          state_nxt = PRIO1;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
    end
  end

  assign gnt0 = gnt[PORT_CPU];
  assign gnt1 = gnt[PORT_AUX];

  // Memory drive: mux the granted port's qualifiers, all zero when idle.
  always_comb begin
    memAddr      = '0;
    memWriteData = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    if (gnt[PORT_AUX]) begin
      memAddr      = addr1;
      memWriteData = wdata1;
      MemWrite     = we1;
      MemRead      = ~we1;
    end else if (gnt[PORT_CPU]) begin
      memAddr      = addr0;
      memWriteData = wdata0;
      MemWrite     = we0;
      MemRead      = ~we0;
    end
  end

  dmem_arb_resp #(.DATA_W(DATA_W)) u_resp0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_en     (gnt0 & ~we0),
    .mem_rdata (memReadData),
    .rvalid    (rvalid0),
    .rdata     (rdata0)
  );

  dmem_arb_resp #(.DATA_W(DATA_W)) u_resp1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_en     (gnt1 & ~we1),
    .mem_rdata (memReadData),
    .rvalid    (rvalid1),
    .rdata     (rdata1)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the arbitration and memory contents.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWriteData, memReadData;
  logic              MemWrite, MemRead;

  int n_total = 0;
  int n_pass  = 0;

  // Memory seen by the DUT, and the model's own copy of what it should hold.
  logic [DATA_W-1:0] env_mem [0:63];
  logic [DATA_W-1:0] ref_mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .gnt0         (gnt0),
    .rvalid0      (rvalid0),
    .rdata0       (rdata0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt1         (gnt1),
    .rvalid1      (rvalid1),
    .rdata1       (rdata1),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .memReadData  (memReadData)
  );

  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  // Single-ported memory: combinational read, write on rising edge.
  assign memReadData = env_mem[memAddr[7:2]];
  always @(posedge clk) begin
    if (MemWrite) env_mem[memAddr[7:2]] <= memWriteData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: port 1 wins if port 0 is idle or port 0 has already
  // been served MAX_HOLD times in a row while port 1 was waiting.
  int unsigned       streak = 0;
  logic              m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [DATA_W-1:0] m_rd0 = '0, m_rd1 = '0;

  always @(negedge clk) begin
    logic              e_g0, e_g1, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    if (!reset_n) begin
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_MemRead", 32'(MemRead), 32'd0);
      check("rst_MemWrite", 32'(MemWrite), 32'd0);
      check("rst_memAddr", memAddr, 32'd0);
      check("rst_memWriteData", memWriteData, 32'd0);
      check("rst_rvalid0", 32'(rvalid0), 32'd0);
      check("rst_rvalid1", 32'(rvalid1), 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      streak = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0;
      m_rd0 = '0;   m_rd1 = '0;
    end else begin
      e_g1   = req1 && (streak >= MAX_HOLD || !req0);
      e_g0   = req0 && !e_g1;
      e_we   = e_g1 ? we1 : (e_g0 ? we0 : 1'b0);
      e_addr = e_g1 ? addr1 : (e_g0 ? addr0 : '0);
      e_wd   = e_g1 ? wdata1 : (e_g0 ? wdata0 : '0);
      check("gnt0", 32'(gnt0), 32'(e_g0));
      check("gnt1", 32'(gnt1), 32'(e_g1));
      check("MemWrite", 32'(MemWrite), 32'((e_g0 || e_g1) && e_we));
      check("MemRead", 32'(MemRead), 32'((e_g0 || e_g1) && !e_we));
      check("memAddr", memAddr, e_addr);
      check("memWriteData", memWriteData, e_wd);
      check("rvalid0", 32'(rvalid0), 32'(m_rv0));
      check("rvalid1", 32'(rvalid1), 32'(m_rv1));
      check("rdata0", rdata0, m_rd0);
      check("rdata1", rdata1, m_rd1);
      // advance model by this cycle's access
      m_rv0 = e_g0 && !we0;
      m_rv1 = e_g1 && !we1;
      if (m_rv0) m_rd0 = ref_mem[addr0[7:2]];
      if (m_rv1) m_rd1 = ref_mem[addr1[7:2]];
      if (e_g0 && we0) ref_mem[addr0[7:2]] = wdata0;
      if (e_g1 && we1) ref_mem[addr1[7:2]] = wdata1;
      streak = (e_g0 && req1) ? streak + 1 : 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int cnt0, cnt1;

  initial begin
    reset_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0;     wdata1 = '0;

    // Reset held with req0 asserted: nothing granted.
    @(negedge clk);
    check("lit_rst_gnt0", 32'(gnt0), 32'd0);
    check("lit_rst_memAddr", memAddr, 32'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    @(negedge clk);
    check("lit_first_gnt0", 32'(gnt0), 32'd1);
    check("lit_first_MemRead", 32'(MemRead), 32'd1);
    check("lit_first_memAddr", memAddr, 32'h10);
    cyc();

    // Port 1 alone: write then read back.
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hDEADBEEF;
    @(negedge clk);
    check("lit_p1_wr_gnt1", 32'(gnt1), 32'd1);
    check("lit_p1_wr_MemWrite", 32'(MemWrite), 32'd1);
    cyc();
    we1 = 1'b0;
    @(negedge clk);
    check("lit_p1_rd_gnt1", 32'(gnt1), 32'd1);
    cyc();
    req1 = 1'b0;
    @(negedge clk);
    check("lit_p1_rvalid1", 32'(rvalid1), 32'd1);
    check("lit_p1_rdata1", rdata1, 32'hDEADBEEF);
    check("lit_p1_rvalid0", 32'(rvalid0), 32'd0);
    cyc();

    // Contention for 20 cycles: 4:1 pattern, never both granted.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("lit_cont_onehot", 32'(gnt0 && gnt1), 32'd0);
      check("lit_cont_gnt1", 32'(gnt1), 32'((i % 5) == 4));
      cnt0 += int'(gnt0);
      cnt1 += int'(gnt1);
      cyc();
    end
    check("lit_cont_cnt0", 32'(cnt0), 32'd16);
    check("lit_cont_cnt1", 32'(cnt1), 32'd4);

    // Starvation release: req1 withdrawn while in PRIO1.
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_starve_gnt0", 32'(gnt0), 32'd1);
      cyc();
    end
    req1 = 1'b0;
    @(negedge clk);
    check("lit_release_gnt0", 32'(gnt0), 32'd1);
    check("lit_release_gnt1", 32'(gnt1), 32'd0);
    cyc();
    req1 = 1'b1;
    @(negedge clk);
    check("lit_after_gnt0", 32'(gnt0), 32'd1);
    check("lit_after_gnt1", 32'(gnt1), 32'd0);
    cyc();

    // Write-then-read hazard across ports.
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h44; wdata0 = 32'hA5A5A5A5;
    cyc();
    we0 = 1'b0;
    cyc();
    we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h12345678;
    @(negedge clk);
    check("lit_haz_rvalid0", 32'(rvalid0), 32'd1);
    check("lit_haz_rdata0", rdata0, 32'hA5A5A5A5);
    cyc();
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
    @(negedge clk);
    check("lit_haz_gnt1", 32'(gnt1), 32'd1);
    cyc();
    req1 = 1'b0;
    @(negedge clk);
    check("lit_haz_rvalid1", 32'(rvalid1), 32'd1);
    check("lit_haz_rdata1", rdata1, 32'h12345678);
    check("lit_haz_rdata0_kept", rdata0, 32'hA5A5A5A5);
    cyc();

    // Idle for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lit_idle_MemRead", 32'(MemRead), 32'd0);
      check("lit_idle_MemWrite", 32'(MemWrite), 32'd0);
      check("lit_idle_memAddr", memAddr, 32'd0);
      check("lit_idle_rvalid", 32'(rvalid0 || rvalid1), 32'd0);
      cyc();
    end

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
      end
      req0   = ($urandom_range(0, 9) < 7);
      we0    = $urandom_range(0, 1) == 1;
      addr0  = 32'($urandom_range(0, 255));
      wdata0 = $urandom;
      req1   = ($urandom_range(0, 9) < 6);
      we1    = $urandom_range(0, 1) == 1;
      addr1  = 32'($urandom_range(0, 255));
      wdata1 = $urandom;
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
